// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared AHB encodings and bridge FSM state constants
package ahb_apb_pkg;
   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ = 2'b11;
   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;
   localparam logic HRESP_OKAY = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_ACCESS = 3'd2;
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;
endpackage

// File: rtl/ahb3lite_apb_bridge_if.sv
// ahb3lite_apb_bridge_if: AHB-Lite slave side and APB3 master side of the bridge
interface ahb3lite_apb_bridge_if #(parameter int ADDR_W = 16);
   logic HSEL;
   logic [31:0] HADDR;
   logic [1:0] HTRANS;
   logic HWRITE;
   logic [2:0] HSIZE;
   logic [3:0] HWSTRB;
   logic [31:0] HWDATA;
   logic HREADYIN;
   logic HREADYOUT;
   logic HRESP;
   logic [31:0] HRDATA;
   logic [ADDR_W-1:0] PADDR;
   logic PSEL;
   logic PENABLE;
   logic PWRITE;
   logic [31:0] PWDATA;
   logic [3:0] PSTRB;
   logic [31:0] PRDATA;
   logic PREADY;
   logic PSLVERR;
   modport slave (
      input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWSTRB, HWDATA, HREADYIN, PRDATA, PREADY, PSLVERR,
      output HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
   );
   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWSTRB, HWDATA, HREADYIN, PRDATA, PREADY, PSLVERR,
      input HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
   );
endinterface

// File: rtl/ahb3lite_apb_timeout.sv
// ahb3lite_apb_timeout: saturating ACCESS watchdog, expire flags the TIMEOUT-th stalled cycle
module ahb3lite_apb_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic clr,
   input  logic inc,
   output logic expire
);
   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign expire = inc && cnt_q >= LAST;
   // clear on SETUP, count stalled ACCESS cycles, hold at the limit
   always_comb begin
      cnt_d = clr ? '0 : (inc && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
   end
   // counter register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ahb3lite_apb_bridge.sv
// ahb3lite_apb_bridge: AHB-Lite beat to APB3 transfer bridge; APB_BRIDGE_TIMEOUT_EN adds an ACCESS watchdog
module ahb3lite_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int TIMEOUT = 255
) (
   input logic HCLK,
   input logic HRESETn,
   ahb3lite_apb_bridge_if.slave bus
);
   logic [2:0] state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic write_q, write_d, bad_q, bad_d;
   logic [3:0] strb_q, strb_d;
   logic hready, take, expire, psel, penable, unused_bits;
   assign hready = state_q == ST_IDLE || state_q == ST_ERR2 ||
                   (state_q == ST_ACCESS && bus.PREADY && !bus.PSLVERR);
   assign take = bus.HSEL && bus.HREADYIN && bus.HTRANS[1] && hready;
   assign psel = (state_q == ST_SETUP && !bad_q) || state_q == ST_ACCESS;
   assign penable = state_q == ST_ACCESS;
   assign unused_bits = ^{bus.HADDR[31:ADDR_W], bus.HTRANS[0]};
`ifdef APB_BRIDGE_TIMEOUT_EN
   ahb3lite_apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .clr(state_q == ST_SETUP),
      .inc(state_q == ST_ACCESS && !bus.PREADY),
      .expire(expire)
   );
`else
   logic unused_timeout;
   assign unused_timeout = TIMEOUT == 0;
   assign expire = 1'b0;
`endif
   // capture the address phase on acceptance and sequence SETUP/ACCESS/error
   always_comb begin
      addr_d = take ? bus.HADDR[ADDR_W-1:0] : addr_q;
      write_d = take ? bus.HWRITE : write_q;
      strb_d = take ? (bus.HWRITE ? bus.HWSTRB : 4'b0000) : strb_q;
      bad_d = take ? bus.HSIZE > HSIZE_WORD : bad_q;
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE, ST_ERR2: state_d = take ? ST_SETUP : ST_IDLE;
         ST_SETUP: state_d = bad_q ? ST_ERR1 : ST_ACCESS;
         ST_ACCESS: state_d = !bus.PREADY ? (expire ? ST_ERR1 : ST_ACCESS) :
                              bus.PSLVERR ? ST_ERR1 : take ? ST_SETUP : ST_IDLE;
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end
   // state and captured transfer registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         addr_q <= '0;
         write_q <= 1'b0;
         strb_q <= 4'b0000;
         bad_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         write_q <= write_d;
         strb_q <= strb_d;
         bad_q <= bad_d;
      end
   end
   assign bus.HREADYOUT = hready;
   assign bus.HRESP = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
   assign bus.HRDATA = penable ? bus.PRDATA : '0;
   assign bus.PSEL = psel;
   assign bus.PENABLE = penable;
   assign bus.PADDR = addr_q;
   assign bus.PWRITE = write_q;
   assign bus.PSTRB = strb_q;
   assign bus.PWDATA = psel ? bus.HWDATA : '0;
endmodule

// File: doc/ahb3lite_apb_bridge.md
Name: ahb3lite_apb_bridge

Overview:
AHB-Lite slave that converts each AHB beat from the burst-capable master adapter into one APB3 transfer: single, SEQ or burst beats alike. It sits directly downstream of the master adapter on the peripheral bus and fronts the low-speed APB peripherals (UART, GPIO, timer). It inserts wait states until PREADY and maps PSLVERR onto the two-cycle AHB ERROR response.

Parameters:
ADDR_W, 16, PADDR width; PADDR = captured HADDR[ADDR_W-1:0]
TIMEOUT, 255, ACCESS-phase cycle limit before forced error (used only with the optional feature)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select from decoder
HADDR  in  32  address-phase address
HTRANS  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HWSTRB  in  4  write byte strobes (address phase)
HWDATA  in  32  write data (data phase)
HREADYIN  in  1  bus-level HREADY
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data
PADDR  out  ADDR_W  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PSTRB  out  4  APB byte strobes
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Valid transfer: HSEL & HREADYIN & HTRANS[1] sampled at the rising edge. BUSY and IDLE are ignored.
- On a valid transfer, register the following and enter SETUP:
  - addr = HADDR[ADDR_W-1:0]
  - write = HWRITE
  - strb = HWRITE ? HWSTRB : 4'b0000
  - bad = (HSIZE > 3'b010)
- States:
  - IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0.
  - SETUP: if bad, go to ERR1 with no APB activity. Otherwise PSEL=1, PENABLE=0, HREADYOUT=0, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=0: stay; HREADYOUT=0.
    - PREADY=1 & PSLVERR=0: HREADYOUT=1, HRESP=0. Next state is SETUP if a new valid transfer is sampled this edge, else IDLE.
    - PREADY=1 & PSLVERR=1: HREADYOUT=0, go to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0. Next state is ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state is SETUP if a valid transfer is sampled this edge (the master may also cancel with IDLE), else IDLE.
- Latency: minimum 3 clocks from address phase to HREADYOUT=1 (address, SETUP, ACCESS with PREADY=1). Back-to-back throughput is one beat per 2 clocks.
- PADDR, PWRITE and PSTRB are driven from the captured registers and are stable from SETUP through ACCESS.
- PWDATA = HWDATA combinationally in SETUP and ACCESS. AHB requires the master to hold HWDATA while HREADYOUT=0, so PWDATA is stable.
- HRDATA = PRDATA in ACCESS, 0 otherwise. It is valid when HREADYOUT=1 and the transfer is an OKAY read.
- A new address phase is sampled only when HREADYOUT=1, i.e. in IDLE, at ACCESS completion, or in ERR2.
- Reset (asynchronous, any state):
  - state returns to IDLE immediately.
  - PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0.
  - PADDR, PWRITE, PSTRB are cleared to 0.
  - An in-flight APB access is abandoned.
- PADDR upper HADDR bits are discarded; the decoder owns range checking.

Optional Feature:
APB_BRIDGE_TIMEOUT_EN
- Compiled in: a counter clears on SETUP and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT, the bridge drops PSEL and PENABLE and goes to ERR1, returning a standard AHB ERROR.
- Compiled out: ACCESS waits on PREADY indefinitely, and the TIMEOUT parameter is unused.

Decomposition:
- Shared package (ahb_apb_pkg): HTRANS encodings, HSIZE encodings, HRESP OKAY/ERROR constants, and the bridge state enum (IDLE, SETUP, ACCESS, ERR1, ERR2).
- One natural sub-module: ahb3lite_apb_timeout, the saturating watchdog counter instantiated only under APB_BRIDGE_TIMEOUT_EN.

Test Plan:
- Single write: NONSEQ, HADDR=0x4000_0010, HWRITE=1, HWSTRB=1111, HWDATA=0xDEADBEEF, PREADY=1 -> PADDR=0x0010, PSTRB=1111, PWDATA=0xDEADBEEF, HREADYOUT high at clock 3, HRESP=0.
- Wait-stated read: PREADY low for 3 cycles, PRDATA=0x1234_5678 -> HREADYOUT low 4 cycles, HRDATA=0x12345678 on the completing clock.
- INCR4 burst: NONSEQ + 3 SEQ from 0x20, word size -> four APB transfers at 0x20, 0x24, 0x28, 0x2C with no idle cycle between; PSEL stays high throughout.
- Slave error: PREADY=1, PSLVERR=1 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); the next NONSEQ is accepted in ERR2.
- Unsupported size: HSIZE=3'b011 -> no PENABLE ever asserted, two-cycle ERROR response.
- Reset during ACCESS: HRESETn low mid-wait -> PSEL=0, PENABLE=0, HREADYOUT=1 in the same cycle. With APB_BRIDGE_TIMEOUT_EN and TIMEOUT=8, PREADY held at 0 -> ERROR after 8 ACCESS cycles.
